// File: rtl/bnn_cmd_controller.sv
// bnn_cmd_controller
//   Byte-level command controller between a UART rx/tx pair and the BNN
//   inference core. Parses LOAD (0xA5), RUN (0x5A) and STATUS (0x3C)
//   opcodes, streams LOAD payload into the image buffer, pulses the core
//   start, and returns ACK/NAK/result/status bytes on the transmit side.
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   baud_clk            one-clk baud tick, drives the LOAD inter-byte timeout
//   rx_data, rx_valid   received byte and its one-cycle strobe
//   img_wr_en/addr/data image buffer write port (combinational from rx)
//   bnn_start           one-cycle inference start pulse
//   bnn_done/result     inference completion strobe and result
//   tx_data, tx_start   byte to send and one-cycle send request
//   tx_busy             transmitter busy
//   busy                controller not in IDLE
//   err                 sticky error flag, cleared by a STATUS query
module bnn_cmd_controller #(
  parameter int IMG_BYTES     = 16,
  parameter int RESULT_W      = 4,
  parameter int TIMEOUT_TICKS = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  baud_clk,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  img_wr_en,
  output logic [((IMG_BYTES > 1) ? $clog2(IMG_BYTES) : 1)-1:0] img_wr_addr,
  output logic [7:0]            img_wr_data,
  output logic                  bnn_start,
  input  logic                  bnn_done,
  input  logic [RESULT_W-1:0]   bnn_result,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic                  busy,
  output logic                  err
);

  localparam int AW = (IMG_BYTES > 1) ? $clog2(IMG_BYTES) : 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [7:0]    OP_LOAD   = 8'hA5;
  localparam logic [7:0]    OP_RUN    = 8'h5A;
  localparam logic [7:0]    OP_STATUS = 8'h3C;
  localparam logic [7:0]    RSP_ACK   = 8'h06;
  localparam logic [7:0]    RSP_NAK   = 8'h15;
  localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_BYTES - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_DONE,
    S_RESPOND,
    S_WAIT_TX_HI,
    S_WAIT_TX_LO
  } state_t;

  state_t        state, state_d;
  logic [AW-1:0] byte_cnt, byte_cnt_d;
  logic [TW-1:0] tick_cnt, tick_cnt_d;
  logic          loaded, loaded_d;
  logic          err_d;
  logic [7:0]    resp, resp_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      byte_cnt <= '0;
      tick_cnt <= '0;
      loaded   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_d;
      byte_cnt <= byte_cnt_d;
      tick_cnt <= tick_cnt_d;
      loaded   <= loaded_d;
      err      <= err_d;
    end
  end

  // Response byte is only visible through tx_data, which is gated by state,
  // so it needs no reset.
  always_ff @(posedge clk) begin
    resp <= resp_d;
  end

  always_comb begin
    state_d     = state;
    byte_cnt_d  = byte_cnt;
    tick_cnt_d  = tick_cnt;
    loaded_d    = loaded;
    err_d       = err;
    resp_d      = resp;
    img_wr_en   = 1'b0;
    img_wr_addr = '0;
    img_wr_data = 8'h00;
    bnn_start   = 1'b0;
    tx_start    = 1'b0;

    case (state)
      S_IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            OP_LOAD: begin
              state_d    = S_LOAD;
              byte_cnt_d = '0;
              tick_cnt_d = '0;
              loaded_d   = 1'b0;
            end
            OP_RUN: begin
              if (loaded) begin
                state_d = S_START;
              end else begin
                resp_d  = RSP_NAK;
                state_d = S_RESPOND;
              end
            end
            OP_STATUS: begin
              // Report err as it stood before this query, then clear it.
              resp_d  = {6'b0, loaded, err};
              err_d   = 1'b0;
              state_d = S_RESPOND;
            end
            default: begin
              err_d   = 1'b1;
              resp_d  = RSP_NAK;
              state_d = S_RESPOND;
            end
          endcase
        end
      end

      S_LOAD: begin
        // A payload byte takes priority over a coincident baud tick.
        if (rx_valid) begin
          img_wr_en   = 1'b1;
          img_wr_addr = byte_cnt;
          img_wr_data = rx_data;
          byte_cnt_d  = byte_cnt + 1'b1;
          tick_cnt_d  = '0;
          if (byte_cnt == LAST_ADDR) begin
            loaded_d = 1'b1;
            resp_d   = RSP_ACK;
            state_d  = S_RESPOND;
          end
        end else if (baud_clk) begin
          if (tick_cnt == LAST_TICK) begin
            err_d   = 1'b1;
            resp_d  = RSP_NAK;
            state_d = S_RESPOND;
          end else begin
            tick_cnt_d = tick_cnt + 1'b1;
          end
        end
      end

      S_START: begin
        bnn_start = 1'b1;
        state_d   = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        if (bnn_done) begin
          resp_d  = 8'h80 | {{(8 - RESULT_W){1'b0}}, bnn_result};
          state_d = S_RESPOND;
        end
      end

      S_RESPOND: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = S_WAIT_TX_HI;
        end
      end

      S_WAIT_TX_HI: begin
        if (tx_busy) state_d = S_WAIT_TX_LO;
      end

      S_WAIT_TX_LO: begin
        if (!tx_busy) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Any byte arriving while a command is in flight is an overrun.
    if (rx_valid && (state != S_IDLE) && (state != S_LOAD)) begin
      err_d = 1'b1;
    end
  end

  assign busy    = (state != S_IDLE);
  assign tx_data = ((state == S_RESPOND) || (state == S_WAIT_TX_HI) ||
                    (state == S_WAIT_TX_LO)) ? resp : 8'h00;

endmodule
